// File: rtl/ring_stack_if.sv
// ring_stack_if: bundles the stack's command and status signals.
//
// Parameters mirror ring_stack (WIDTH, DEPTH, VISIBLES); CW is the count width.
// Signals:
//   push, pop, insert, clear_flags           - commands from the user (master)
//   tops, count, empty, full, overflow, underflow - status from the stack (slave)
// Modports:
//   master - user side: drives commands and observes status.
//   slave  - stack side: observes commands and drives status.
interface ring_stack_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned VISIBLES = 3
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                              push;
  logic                              pop;
  logic [WIDTH-1:0]                  insert;
  logic                              clear_flags;
  logic [VISIBLES-1:0][WIDTH-1:0]    tops;
  logic [CW-1:0]                     count;
  logic                              empty;
  logic                              full;
  logic                              overflow;
  logic                              underflow;

  modport master (
    output push, pop, insert, clear_flags,
    input  tops, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, insert, clear_flags,
    output tops, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/ring_stack.sv
// ring_stack: register-based LIFO of DEPTH entries, WIDTH bits each, held in a circular array
// addressed by a top pointer. The VISIBLES top entries are readable combinationally.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - ring_stack_if.slave:
//     push/pop/insert  - push, pop, or both at once (both = replace top)
//     clear_flags      - synchronous clear of the sticky flags (a set in the same cycle wins)
//     tops             - tops[0] = top, tops[1] = next, ...; slots beyond count read 0
//     count/empty/full - occupancy
//     overflow         - sticky: push while full without pop
//     underflow        - sticky: pop while empty
//
// Build option: define RING_STACK_WRAP_EN to make a push while full overwrite the oldest entry.
// Without it such a push is dropped. overflow is set either way.
module ring_stack #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned VISIBLES = 3
) (
  input logic        clk,
  input logic        reset,
  ring_stack_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LastIdx   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    tp_q, tp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wr_en;
  logic [PW-1:0]    wr_addr;
  logic             set_ovf, set_unf;
  logic             is_empty, is_full;
  logic [PW-1:0]    tp_inc, tp_dec;

  logic [VISIBLES-1:0][WIDTH-1:0] tops;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FullCount);

  // Pointer arithmetic modulo DEPTH; DEPTH need not be a power of two.
  assign tp_inc = (tp_q == LastIdx) ? '0 : tp_q + 1'b1;
  assign tp_dec = (tp_q == '0) ? LastIdx : tp_q - 1'b1;

  // Map the k-th visible slot to its array index: (tp - k) mod DEPTH.
  function automatic logic [PW-1:0] slot_of(input logic [PW-1:0] tp, input int unsigned k);
    int unsigned idx;
    idx = 32'(tp) + DEPTH - k;
    if (idx >= DEPTH) idx = idx - DEPTH;
    return PW'(idx);
  endfunction

  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = tp_q;
    set_ovf = 1'b0;
    set_unf = 1'b0;

    if (bus.push && bus.pop && !is_empty) begin
      // Replace top: pointer, count and flags untouched, even when full.
      wr_en = 1'b1;
    end else if (bus.push) begin
      // Push+pop on an empty stack degrades to a push but still reports underflow.
      set_unf = bus.pop;
      if (!is_full) begin
        tp_d    = tp_inc;
        count_d = count_q + 1'b1;
        wr_en   = 1'b1;
        wr_addr = tp_inc;
      end else begin
        set_ovf = 1'b1;
`ifdef RING_STACK_WRAP_EN
        // When full, the slot after top holds the oldest entry; overwrite it.
        tp_d    = tp_inc;
        wr_en   = 1'b1;
        wr_addr = tp_inc;
`endif
      end
    end else if (bus.pop) begin
      if (is_empty) begin
        set_unf = 1'b1;
      end else begin
        tp_d    = tp_dec;
        count_d = count_q - 1'b1;
      end
    end

    overflow_d  = set_ovf | (overflow_q & ~bus.clear_flags);
    underflow_d = set_unf | (underflow_q & ~bus.clear_flags);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tp_q        <= tp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= bus.insert;
    end
  end

  always_comb begin
    tops = '0;
    for (int unsigned k = 0; k < VISIBLES; k++) begin
      if (k < 32'(count_q)) tops[k] = mem_q[slot_of(tp_q, k)];
    end
  end

  assign bus.tops      = tops;
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: doc/ring_stack.md
# ring_stack

Parametrised successor to the core's fixed call/loop stack primitive. It is a register-based LIFO with DEPTH entries of WIDTH bits and VISIBLES combinationally readable top entries. It adds occupancy reporting, sticky overflow/underflow flags, and a defined simultaneous push+pop (replace-top) operation. It backs the cstack and lstack in the next core revision and is sized per instance.

## Interface
- WIDTH, 32, bits per entry
- DEPTH, 8, number of entries; must be ≥ 2
- VISIBLES, 3, number of top entries exposed; 1 ≤ VISIBLES ≤ DEPTH
- CW (localparam), $clog2(DEPTH+1), width of count

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- push  input  1  write insert as new top this cycle
- pop  input  1  remove top this cycle
- insert  input  WIDTH  data for push
- clear_flags  input  1  synchronously clears overflow and underflow
- tops  output  [VISIBLES][WIDTH]  tops[0] = top, tops[1] = next, ...
- count  output  CW  current number of valid entries, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky: a push was attempted while full without pop
- underflow  output  1  sticky: a pop was attempted while empty

## Operation
- Storage is a circular array addressed by a top pointer `tp` (mod DEPTH); no entry shifting.
- Push only, not full: tp ← tp+1 mod DEPTH, mem[tp+1] ← insert, count+1.
- Pop only, not empty: tp ← tp−1 mod DEPTH, count−1. The vacated entry is not cleared.
- Push and pop, count ≥ 1: mem[tp] ← insert; tp and count unchanged; no flag change, even when full.
- Push and pop, count == 0: behaves as push only (count becomes 1); underflow set.
- Pop only, empty: no state change; underflow set.
- Push only, full: overflow set; data handling per Configuration.
- tops[k] = mem[tp−k mod DEPTH] when k < count, else 0. Invalid visible slots always read 0.
- clear_flags has lower priority than setting: if a flag event occurs in the same cycle as clear_flags, the flag is 1 afterwards.
- empty and full are derived combinationally from count.

## Timing
- All state updates on the rising edge of clk. Effects are visible on tops and count the cycle after push/pop is sampled.
- Outputs are combinational from registers; there is no input-to-output combinational path.
- Reset (reset = 0, asynchronous, any time including mid-operation): tp = 0, count = 0, every mem entry = 0, overflow = 0, underflow = 0. Consequently tops = all 0, empty = 1, full = 0.
- Deassertion of reset takes effect at the first rising edge with reset = 1. Push/pop sampled at that edge are honoured.
- Back-to-back push/pop every cycle is supported with no bubbles.

## Configuration
- RING_STACK_WRAP_EN defined: push while full overwrites the oldest entry.
  - tp advances and count stays DEPTH, so the stack retains the newest DEPTH values.
  - Intended for the lstack, whose outermost loop may be discarded.
- RING_STACK_WRAP_EN undefined: push while full is dropped.
  - tp, count and mem are unchanged; tops keep the existing contents.
- overflow is set in both builds.

## Test plan
- Reset/idle: hold reset = 0 mid-sequence after 3 pushes → count = 0, empty = 1, tops all 0, flags 0, with no clock edge required.
- Fill/drain (DEPTH = 8, VISIBLES = 3): push 1..8 → full = 1, tops = {8,7,6}. Then pop 8 times → tops sequence ends {0,0,0}, empty = 1, no flags.
- Overflow, WRAP_EN defined: after 1..8, push 9 → overflow = 1, count = 8, tops = {9,8,7}. Pop 8 times; the last popped value is 2.
- Overflow, WRAP_EN undefined: same stimulus → overflow = 1, tops = {8,7,6}, count = 8.
- Replace-top: stack {5,6} (top 6), push+pop with insert = 0xA → tops = {0xA,5,0}, count = 2. On an empty stack, push+pop 0xB → count = 1, tops[0] = 0xB, underflow = 1.
- Flags: pop on empty → underflow = 1. clear_flags alone → 0. clear_flags together with pop on empty → underflow stays 1.
